// File: rtl/i2c_sensor_poller_if.sv
// Byte-level I2C master handshake between the sensor poller (master side)
// and the I2C byte engine (slave side).
interface i2c_sensor_poller_if;
  logic       i2c_ena;
  logic [6:0] i2c_addr;
  logic       i2c_rw;
  logic [7:0] i2c_data_wr;
  logic       i2c_busy;
  logic [7:0] i2c_data_rd;
  logic       i2c_ack_err;

  modport master (
    output i2c_ena, i2c_addr, i2c_rw, i2c_data_wr,
    input  i2c_busy, i2c_data_rd, i2c_ack_err
  );

  modport slave (
    input  i2c_ena, i2c_addr, i2c_rw, i2c_data_wr,
    output i2c_busy, i2c_data_rd, i2c_ack_err
  );
endinterface

// File: rtl/i2c_sensor_poller.sv
// Periodic poller for NUM_SENSORS I2C temperature sensors: pointer write,
// repeated start, multi-byte read; emits a channel-tagged result stream.
module i2c_sensor_poller #(
  parameter int          NUM_SENSORS    = 2,
  parameter int          BYTES_PER_READ = 2,
  parameter int          POLL_CYCLES    = 50000,
  parameter logic [6:0]  ADDR_BASE      = 7'h48,
  parameter logic [7:0]  REG_PTR        = 8'h00,
  localparam int         CW             = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        en,
  i2c_sensor_poller_if.master         i2c,
  output logic [8*BYTES_PER_READ-1:0] rd_data,
  output logic [CW-1:0]               rd_chan,
  output logic                        rd_valid,
  output logic                        err,
  output logic                        overrun
);
  localparam int              TW         = $clog2(POLL_CYCLES);
  localparam int              DW         = 8 * BYTES_PER_READ;
  localparam logic [TW-1:0]   TIMER_LOAD = TW'(POLL_CYCLES - 1);
  localparam logic [2:0]      RCNT_LAST  = 3'(BYTES_PER_READ + 1);
  localparam logic [CW-1:0]   CHAN_LAST  = CW'(NUM_SENSORS - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0, IDLE = 3'd1, START = 3'd2, XFER = 3'd3,
    STORE = 3'd4, ABORT = 3'd5, NEXT = 3'd6
  } state_t;

  state_t          state_r, state_next;
  logic [TW-1:0]   count_r;
  logic            busy_q_r;
  logic            tick_s, rise_s, fall_s;
  logic [CW-1:0]   chan_r, chan_next;
  logic [2:0]      rcnt_r, rcnt_next;
  logic [DW-1:0]   cap_r, cap_next;
  logic            ena_r, ena_next, rw_r, rw_next;
  logic [6:0]      addr_r, addr_next;
  logic [7:0]      data_wr_r, data_wr_next;
  logic [DW-1:0]   rd_data_r, rd_data_next;
  logic [CW-1:0]   rd_chan_r, rd_chan_next;
  logic            rd_valid_r, rd_valid_next, err_r, err_next;
  logic            overrun_r, overrun_next;

  assign tick_s = (count_r == '0);
  assign rise_s = i2c.i2c_busy & ~busy_q_r;
  assign fall_s = ~i2c.i2c_busy & busy_q_r;

  // Poll period timer, free-running independent of en
  always_ff @(posedge CLK) begin
    if (!RST) begin
      count_r <= TIMER_LOAD;
    end else if (tick_s) begin
      count_r <= TIMER_LOAD;
    end else begin
      count_r <= count_r - TW'(1);
    end
  end

  // Busy edge-detect register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      busy_q_r <= 1'b0;
    end else begin
      busy_q_r <= i2c.i2c_busy;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next    = state_r;
    chan_next     = chan_r;
    rcnt_next     = rcnt_r;
    cap_next      = cap_r;
    ena_next      = ena_r;
    addr_next     = addr_r;
    rw_next       = rw_r;
    data_wr_next  = data_wr_r;
    rd_data_next  = rd_data_r;
    rd_chan_next  = rd_chan_r;
    rd_valid_next = 1'b0;
    err_next      = 1'b0;
    if (tick_s && (state_r != IDLE)) begin
      overrun_next = 1'b1;
    end else begin
      overrun_next = overrun_r;
    end

    case (state_r)
      WAIT_IDLE: begin
        if (!i2c.i2c_busy) state_next = IDLE;
        else               state_next = WAIT_IDLE;
      end
      IDLE: begin
        if (tick_s && en) begin
          chan_next  = '0;
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        addr_next    = ADDR_BASE + 7'(chan_r);
        rw_next      = 1'b0;
        data_wr_next = REG_PTR;
        ena_next     = 1'b1;
        rcnt_next    = 3'd0;
        state_next   = XFER;
      end
      XFER: begin
        if (rise_s) begin
          // ena stays high through the repeated start until the last read byte begins
          rcnt_next = rcnt_r + 3'd1;
          if (rcnt_next == 3'd1) rw_next = 1'b1;
          else                   rw_next = rw_r;
          if (rcnt_next == RCNT_LAST) ena_next = 1'b0;
          else                        ena_next = ena_r;
        end else if (fall_s) begin
          for (int k = 0; k < BYTES_PER_READ; k++) begin
            if (rcnt_r == 3'(k + 2)) cap_next[8*(BYTES_PER_READ-1-k) +: 8] = i2c.i2c_data_rd;
            else                     cap_next[8*(BYTES_PER_READ-1-k) +: 8] = cap_r[8*(BYTES_PER_READ-1-k) +: 8];
          end
          if (i2c.i2c_ack_err) begin
            ena_next   = 1'b0;
            state_next = ABORT;
          end else if (rcnt_r == RCNT_LAST) begin
            state_next = STORE;
          end else begin
            state_next = XFER;
          end
        end else begin
          state_next = XFER;
        end
      end
      STORE: begin
        rd_data_next  = cap_r;
        rd_chan_next  = chan_r;
        rd_valid_next = 1'b1;
        state_next    = NEXT;
      end
      ABORT: begin
        if (!i2c.i2c_busy) begin
          err_next     = 1'b1;
          rd_chan_next = chan_r;
          state_next   = NEXT;
        end else begin
          state_next = ABORT;
        end
      end
      NEXT: begin
        if ((chan_r == CHAN_LAST) || !en) begin
          chan_next  = '0;
          state_next = IDLE;
        end else begin
          chan_next  = chan_r + CW'(1);
          state_next = START;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r    <= WAIT_IDLE;
      chan_r     <= '0;
      rcnt_r     <= 3'd0;
      cap_r      <= '0;
      ena_r      <= 1'b0;
      addr_r     <= 7'h00;
      rw_r       <= 1'b0;
      data_wr_r  <= 8'h00;
      rd_data_r  <= '0;
      rd_chan_r  <= '0;
      rd_valid_r <= 1'b0;
      err_r      <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_next;
      chan_r     <= chan_next;
      rcnt_r     <= rcnt_next;
      cap_r      <= cap_next;
      ena_r      <= ena_next;
      addr_r     <= addr_next;
      rw_r       <= rw_next;
      data_wr_r  <= data_wr_next;
      rd_data_r  <= rd_data_next;
      rd_chan_r  <= rd_chan_next;
      rd_valid_r <= rd_valid_next;
      err_r      <= err_next;
      overrun_r  <= overrun_next;
    end
  end

  assign i2c.i2c_ena     = ena_r;
  assign i2c.i2c_addr    = addr_r;
  assign i2c.i2c_rw      = rw_r;
  assign i2c.i2c_data_wr = data_wr_r;
  assign rd_data         = rd_data_r;
  assign rd_chan         = rd_chan_r;
  assign rd_valid        = rd_valid_r;
  assign err             = err_r;
  assign overrun         = overrun_r;
endmodule

// File: tb/tb_i2c_sensor_poller.sv
// Bench for i2c_sensor_poller: behavioural byte-level I2C master plus a
// result scoreboard and a table of sweep vectors.
module tb_i2c_sensor_poller;
  localparam int P = 100;

  typedef struct packed {
    logic        vld;
    logic        er;
    logic [0:0]  chan;
    logic [15:0] data;
  } ev_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic        rw;
    logic [7:0]  dw;
    logic [31:0] cyc;
  } txn_t;

  typedef struct packed {
    logic [15:0] w0;
    logic [15:0] w1;
    logic        nack1;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic        exp_err1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [15:0] rd_data;
  logic [0:0]  rd_chan;
  logic        rd_valid, err, overrun;

  i2c_sensor_poller_if bus ();

  i2c_sensor_poller #(
    .NUM_SENSORS(2), .BYTES_PER_READ(2), .POLL_CYCLES(P),
    .ADDR_BASE(7'h48), .REG_PTR(8'h00)
  ) dut (
    .CLK(clk), .RST(rst), .en(en), .i2c(bus),
    .rd_data(rd_data), .rd_chan(rd_chan), .rd_valid(rd_valid),
    .err(err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BFM configuration (written by the test) and transaction log (written by the BFM)
  int          byte_cycles = 8;
  logic [15:0] word_tab [0:1];
  logic [6:0]  nack_addr = 7'h7f;
  txn_t        txn_log [0:255];
  int          txn_n = 0;

  // Behavioural byte-level I2C master
  initial begin : bfm
    int          rd_idx;
    logic        cur_rw;
    logic [6:0]  cur_addr;
    logic [15:0] w;
    txn_t        t;
    rd_idx = 0;
    bus.i2c_busy    = 1'b0;
    bus.i2c_data_rd = 8'h00;
    bus.i2c_ack_err = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.i2c_ena) begin
        cur_rw   = bus.i2c_rw;
        cur_addr = bus.i2c_addr;
        t.addr = cur_addr; t.rw = cur_rw; t.dw = bus.i2c_data_wr; t.cyc = 32'(cyc);
        txn_log[8'(txn_n)] = t;
        txn_n = txn_n + 1;
        bus.i2c_ack_err = 1'b0;
        bus.i2c_busy    = 1'b1;
        repeat (byte_cycles) @(posedge clk);
        #1;
        if (!cur_rw) begin
          rd_idx = 0;
          bus.i2c_ack_err = (cur_addr == nack_addr);
        end else begin
          w = (cur_addr == 7'h49) ? word_tab[1] : word_tab[0];
          bus.i2c_data_rd = (rd_idx == 0) ? w[15:8] : w[7:0];
          rd_idx = rd_idx + 1;
        end
        bus.i2c_busy = 1'b0;
      end
    end
  end

  // Output monitor: records every result/error strobe
  ev_t obs_arr [0:255];
  int  obs_n = 0;
  always @(negedge clk) begin
    if (rd_valid || err) begin
      obs_arr[8'(obs_n)] <= '{vld: rd_valid, er: err, chan: rd_chan, data: rd_data};
      obs_n <= obs_n + 1;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int   checks = 0;
  int   errors = 0;
  int   obs_rd = 0;
  ev_t  exp_q [$];
  vec_t vecs [0:3];
  int   start_cyc [0:3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ev_t mk_ev(input logic v, input logic e, input logic c, input logic [15:0] d);
    ev_t r;
    r.vld = v; r.er = e; r.chan = c; r.data = d;
    return r;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, " i2c_ena"},  32'(bus.i2c_ena), 32'd0);
    chk({tag, " i2c_addr"}, 32'(bus.i2c_addr), 32'd0);
    chk({tag, " i2c_rw"},   32'(bus.i2c_rw), 32'd0);
    chk({tag, " data_wr"},  32'(bus.i2c_data_wr), 32'd0);
    chk({tag, " rd_data"},  32'(rd_data), 32'd0);
    chk({tag, " rd_chan"},  32'(rd_chan), 32'd0);
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, " err"},      32'(err), 32'd0);
    chk({tag, " overrun"},  32'(overrun), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    obs_rd = obs_n;
  endtask

  // Wait for all queued expectations, then compare in order and reject extras
  task automatic drain(input int bound, input string name);
    int  n;
    ev_t o, e;
    n = 0;
    while (((obs_n - obs_rd) < exp_q.size()) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk({name, " timeout"}, 32'((obs_n - obs_rd) >= exp_q.size()), 32'd1);
    while ((exp_q.size() > 0) && (obs_rd < obs_n)) begin
      o = obs_arr[8'(obs_rd)];
      e = exp_q.pop_front();
      obs_rd++;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s event: got vld=%0b err=%0b chan=%0d data=%h expected vld=%0b err=%0b chan=%0d data=%h",
                 name, o.vld, o.er, o.chan, o.data, e.vld, e.er, e.chan, e.data);
      end
    end
    exp_q.delete();
    chk({name, " extra events"}, 32'(obs_n - obs_rd), 32'd0);
    obs_rd = obs_n;
  endtask

  initial begin : main
    int   t0, n;
    logic seen;
    txn_t t;

    vecs[0] = '{w0: 16'h1980, w1: 16'h1A40, nack1: 1'b0, exp0: 16'h1980, exp1: 16'h1A40, exp_err1: 1'b0};
    vecs[1] = '{w0: 16'h0190, w1: 16'hFF70, nack1: 1'b0, exp0: 16'h0190, exp1: 16'hFF70, exp_err1: 1'b0};
    vecs[2] = '{w0: 16'h1980, w1: 16'h1A40, nack1: 1'b1, exp0: 16'h1980, exp1: 16'h1980, exp_err1: 1'b1};
    vecs[3] = '{w0: 16'h2233, w1: 16'h4455, nack1: 1'b0, exp0: 16'h2233, exp1: 16'h4455, exp_err1: 1'b0};
    word_tab[0] = 16'h0000;
    word_tab[1] = 16'h0000;

    // Reset then idle with en low
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.i2c_ena) seen = 1'b1;
    end
    chk("idle ena never rose", 32'(seen), 32'd0);
    chk_zero("idle");

    // Table-driven sweeps
    do_reset();
    en = 1'b1;
    for (int v = 0; v < 4; v++) begin
      word_tab[0] = vecs[v].w0;
      word_tab[1] = vecs[v].w1;
      nack_addr   = vecs[v].nack1 ? 7'h49 : 7'h7f;
      t0 = txn_n;
      exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, vecs[v].exp0));
      exp_q.push_back(mk_ev(~vecs[v].exp_err1, vecs[v].exp_err1, 1'b1, vecs[v].exp1));
      drain(400, "sweep");
      t = txn_log[8'(t0)];
      start_cyc[v] = int'(t.cyc);
      chk("first txn addr", 32'(t.addr), 32'h48);
      chk("first txn rw", 32'(t.rw), 32'd0);
      chk("first txn ptr", 32'(t.dw), 32'h00);
      t = txn_log[8'(t0 + 1)];
      chk("restart read rw", 32'(t.rw), 32'd1);
      t = txn_log[8'(t0 + 3)];
      chk("ch1 ptr write addr", 32'(t.addr), 32'h49);
    end
    chk("sweep period 0-1", 32'(start_cyc[1] - start_cyc[0]), 32'(P));
    chk("sweep period 2-3", 32'(start_cyc[3] - start_cyc[2]), 32'(P));

    // en dropped during channel 0 read
    en = 1'b0;
    do_reset();
    nack_addr = 7'h7f;
    word_tab[0] = 16'h1980;
    word_tab[1] = 16'h1A40;
    en = 1'b1;
    t0 = txn_n;
    n = 0;
    while ((txn_n < t0 + 2) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    chk("en drop read started", 32'(txn_n >= t0 + 2), 32'd1);
    en = 1'b0;
    exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 16'h1980));
    drain(200, "en drop");
    repeat (200) @(negedge clk);
    chk("en drop txn count", 32'(txn_n - t0), 32'd3);
    chk("en drop ena low", 32'(bus.i2c_ena), 32'd0);
    chk("en drop no events", 32'(obs_n - obs_rd), 32'd0);

    // Overrun: sweeps longer than the poll period
    do_reset();
    byte_cycles = 40;
    en = 1'b1;
    for (int s = 0; s < 2; s++) begin
      exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 16'h1980));
      exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b1, 16'h1A40));
      drain(1500, "overrun sweep");
      chk("overrun sticky", 32'(overrun), 32'd1);
    end

    // Reset while the master is busy
    n = 0;
    while (!bus.i2c_busy && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    chk("busy before reset", 32'(bus.i2c_busy), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid-read reset ena", 32'(bus.i2c_ena), 32'd0);
    chk("mid-read reset overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    byte_cycles = 8;
    t0 = txn_n;
    seen = 1'b0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (bus.i2c_ena) seen = 1'b1;
    end
    chk("no start before tick", 32'(seen), 32'd0);
    chk("no txn before tick", 32'(txn_n - t0), 32'd0);
    obs_rd = obs_n;
    exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 16'h1980));
    exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b1, 16'h1A40));
    drain(400, "post reset sweep");
    t = txn_log[8'(t0)];
    chk("post reset first addr", 32'(t.addr), 32'h48);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
